// File: rtl/burst_seq_if.sv
// Request/handshake/status bundle between a burst requester and burst_seq_ctrl.
// master = the sequencer side, slave = the requester / address consumer side.
interface burst_seq_if #(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 8,
   parameter int WS_W   = 2
);
   logic              en;
   logic [1:0]        mode_sel;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  burst_len;
   logic              stop_signal;
   logic              addr_ready;
   logic [ADDR_W-1:0] addr_out;
   logic              addr_valid;
   logic [WS_W-1:0]   word_sel;
   logic              last;
   logic              busy;
   logic              done;
   logic              aborted;
   logic              err;

   modport master (
      input  en, mode_sel, start, start_addr, burst_len, stop_signal, addr_ready,
      output addr_out, addr_valid, word_sel, last, busy, done, aborted, err
   );

   modport slave (
      output en, mode_sel, start, start_addr, burst_len, stop_signal, addr_ready,
      input  addr_out, addr_valid, word_sel, last, busy, done, aborted, err
   );
endinterface

// File: rtl/burst_seq_ctrl.sv
// Burst address sequencer: issues WORDS serial words per address beat in single,
// incrementing or (with macro BURST_WRAP_EN) wrapping mode, with abort and status flags.
module burst_seq_ctrl #(
   parameter int ADDR_W    = 24,
   parameter int LEN_W     = 8,
   parameter int WORDS     = 4,
   parameter int ADDR_STEP = 1,
   localparam int WS_W     = $clog2(WORDS)
) (
   input  logic        clk,
   input  logic        rst,
   burst_seq_if.master bus
);
   typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [WS_W-1:0]   word_reg;
   logic [LEN_W-1:0]  beat_cnt_reg;
   logic [LEN_W-1:0]  last_beat_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              aborted_reg;
   logic              err_reg;

   logic [LEN_W-1:0]  len_eff;
   logic [LEN_W-1:0]  last_beat_next;
   logic              single_mode;
   logic              wrap_mode;
   logic              err_next;
   logic              handshake;
   logic              word_last;
   logic              beat_last;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] addr_adv;

   // Mode 11 is reserved and behaves like single.
   assign single_mode    = (bus.mode_sel == 2'b00) || (bus.mode_sel == 2'b11);
   assign wrap_mode      = (bus.mode_sel == 2'b10);
   assign len_eff        = (bus.burst_len == '0) ? LEN_W'(1) : bus.burst_len;
   assign last_beat_next = single_mode ? '0 : (len_eff - LEN_W'(1));

   assign handshake = (state_reg == XFER) && bus.en && bus.addr_ready;
   assign word_last = (word_reg == WS_W'(WORDS - 1));
   assign beat_last = (beat_cnt_reg == last_beat_reg);
   assign addr_inc  = addr_reg + ADDR_W'(ADDR_STEP);

`ifdef BURST_WRAP_EN
   logic              wrap_reg;
   logic [ADDR_W-1:0] wrap_mask_reg;
   logic [ADDR_W-1:0] wrap_mask_next;
   logic [31:0]       len32;
   logic              len_legal;

   assign len32          = 32'(bus.burst_len);
   assign len_legal      = (len32 == 32'd2) || (len32 == 32'd4) ||
                           (len32 == 32'd8) || (len32 == 32'd16);
   // Wrap block is burst_len*ADDR_STEP bytes; ADDR_STEP is expected to be a power of two.
   assign wrap_mask_next = ADDR_W'(len32 * 32'(ADDR_STEP) - 32'd1);
   assign err_next       = wrap_mode && !len_legal;
   assign addr_adv       = wrap_reg ? ((addr_reg & ~wrap_mask_reg) | (addr_inc & wrap_mask_reg))
                                    : addr_inc;
`else
   assign err_next = wrap_mode;
   assign addr_adv = addr_inc;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         word_reg      <= '0;
         beat_cnt_reg  <= '0;
         last_beat_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         aborted_reg   <= 1'b0;
         err_reg       <= 1'b0;
`ifdef BURST_WRAP_EN
         wrap_reg      <= 1'b0;
         wrap_mask_reg <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start && bus.en) begin
                  state_reg     <= LOAD;
                  addr_reg      <= bus.start_addr;
                  word_reg      <= '0;
                  beat_cnt_reg  <= '0;
                  last_beat_reg <= last_beat_next;
                  busy_reg      <= 1'b1;
                  aborted_reg   <= 1'b0;
                  err_reg       <= err_next;
`ifdef BURST_WRAP_EN
                  wrap_reg      <= wrap_mode && len_legal;
                  wrap_mask_reg <= wrap_mask_next;
`endif
               end
            end
            LOAD: begin
               if (bus.stop_signal) begin
                  state_reg   <= DONE;
                  done_reg    <= 1'b1;
                  aborted_reg <= 1'b1;
               end else begin
                  state_reg <= XFER;
               end
            end
            XFER: begin
               if (handshake) begin
                  if (word_last) begin
                     word_reg     <= '0;
                     addr_reg     <= addr_adv;
                     beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
                  end else begin
                     word_reg <= word_reg + WS_W'(1);
                  end
               end
               // An abort still lets a handshake on the same edge complete (above).
               if (bus.stop_signal) begin
                  state_reg   <= DONE;
                  done_reg    <= 1'b1;
                  aborted_reg <= 1'b1;
               end else if (handshake && word_last && beat_last) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.addr_out   = addr_reg;
   assign bus.word_sel   = word_reg;
   assign bus.addr_valid = (state_reg == XFER) && bus.en;
   assign bus.last       = (state_reg == XFER) && word_last && beat_last;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.aborted    = aborted_reg;
   assign bus.err        = err_reg;
endmodule
